// File: rtl/info_mapper_pkg.sv
// Shared helpers and defaults for the info-bit mapper family.
package info_mapper_pkg;

   localparam bit FROZEN_VAL_DEFAULT = 1'b0;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Width of the buffer fill counter (must represent 0..P+IN_W).
   function automatic int cnt_w(input int p, input int in_w);
      return clog2(p + in_w + 1);
   endfunction

   // Width of a lane prefix sum (must represent 0..P).
   function automatic int prefix_w(input int p);
      return clog2(p + 1);
   endfunction

endpackage

// File: rtl/info_lane_mapper.sv
// Combinational lane mapper: places window bits, in order, into the lanes
// whose mask bit is set and drives the frozen value everywhere else.
module info_lane_mapper
   import info_mapper_pkg::*;
#(
   parameter int P  = 8,
   parameter int KW = prefix_w(P)
) (
   input  logic [P-1:0]  em_i,
   input  logic [P-1:0]  window_i,
   input  logic          frozen_i,
   output logic [P-1:0]  word_o,
   output logic [KW-1:0] k_o
);

   localparam logic [P-1:0] ONE = P'(1);

   // pre[i] = number of information lanes below lane i
   logic [KW-1:0] pre [P+1];

   assign pre[0] = '0;

   // Prefix-sum chain plus per-lane select; pre[i] <= i so the select stays in the window.
   for (genvar i = 0; i < P; i++) begin : g_lane
      assign pre[i+1]  = pre[i] + KW'(em_i[i]);
      assign word_o[i] = em_i[i] ? |(window_i & (ONE << pre[i])) : frozen_i;
   end

   assign k_o = pre[P];

endmodule

// File: rtl/info_mapper_stream.sv
// Streaming information-bit mapper: buffers incoming info words as a bit
// stream and emits P-lane words with info bits in mask-1 lanes.
module info_mapper_stream
   import info_mapper_pkg::*;
#(
   parameter int P                  = 8,
   parameter int IN_W               = 8,
   parameter int FRAME_WORDS        = 4,
   parameter bit FROZEN_VAL         = FROZEN_VAL_DEFAULT,
   parameter bit FLUSH_AT_FRAME_END = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [IN_W-1:0] data_in_fifo_rd_data,
   input  logic            data_in_valid,
   output logic            data_in_ready,
   input  logic [P-1:0]    mapping_indicators,
   input  logic            mapping_valid,
   output logic            mapping_ready,
   input  logic            bypass,
   output logic [P-1:0]    data_out_fifo_wr_data,
   output logic            data_out_valid,
   input  logic            data_out_ready,
   output logic            data_out_last,
   output logic [15:0]     frame_count
);

   localparam int BUF_BITS = P + IN_W;
   localparam int CW       = cnt_w(P, IN_W);
   localparam int KW       = prefix_w(P);
   localparam int WCW      = (FRAME_WORDS > 1) ? clog2(FRAME_WORDS) : 1;
   localparam logic [BUF_BITS-1:0] IN_MASK = {{P{1'b0}}, {IN_W{1'b1}}};

   logic [BUF_BITS-1:0] bits_q, bits_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [P-1:0]        word_q, word_d;
   logic                vld_q, vld_d;
   logic                last_q, last_d;
   logic [WCW-1:0]      wcnt_q, wcnt_d;
   logic [15:0]         fc_q, fc_d;

   logic [P-1:0]        em;
   logic [P-1:0]        mapped;
   logic [KW-1:0]       k;
   logic                in_fire, load, accept, is_last;
   logic [BUF_BITS-1:0] kept;
   logic [CW-1:0]       base;

   assign em            = bypass ? '1 : mapping_indicators;
   assign data_in_ready = (cnt_q <= CW'(BUF_BITS - IN_W));
   assign in_fire       = data_in_valid && data_in_ready;
   // Uses the registered fill only: bits arriving this cycle cannot be mapped yet.
   assign load          = mapping_valid && (!vld_q || data_out_ready) && (cnt_q >= CW'(k));
   assign accept        = vld_q && data_out_ready;
   assign is_last       = (wcnt_q == WCW'(FRAME_WORDS - 1));
   assign mapping_ready = load;

   info_lane_mapper #(
      .P  (P),
      .KW (KW)
   ) u_lane_mapper (
      .em_i     (em),
      .window_i (bits_q[P-1:0]),
      .frozen_i (FROZEN_VAL),
      .word_o   (mapped),
      .k_o      (k)
   );

   // Next-state: consume k bits on load, then append the input word above what remains.
   always_comb begin
      kept   = bits_q;
      base   = cnt_q;
      bits_d = bits_q;
      cnt_d  = cnt_q;
      word_d = word_q;
      vld_d  = vld_q;
      last_d = last_q;
      wcnt_d = wcnt_q;
      fc_d   = fc_q;

      if (load) begin
         kept = bits_q >> k;
         base = cnt_q - CW'(k);
         if (FLUSH_AT_FRAME_END && is_last) begin
            kept = '0;
            base = '0;
         end
      end
      bits_d = kept;
      cnt_d  = base;
      if (in_fire) begin
         bits_d = (kept & ~(IN_MASK << base)) | (BUF_BITS'(data_in_fifo_rd_data) << base);
         cnt_d  = base + CW'(IN_W);
      end

      if (load) begin
         word_d = mapped;
         vld_d  = 1'b1;
         last_d = is_last;
         wcnt_d = is_last ? '0 : wcnt_q + 1'b1;
      end else if (accept) begin
         vld_d  = 1'b0;
         last_d = 1'b0;
      end

      if (accept && last_q) fc_d = fc_q + 16'd1;
   end

   // State registers with synchronous reset; reset drops buffered bits and any pending word.
   always_ff @(posedge clk) begin
      if (reset) begin
         bits_q <= '0;
         cnt_q  <= '0;
         word_q <= '0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         wcnt_q <= '0;
         fc_q   <= '0;
      end else begin
         bits_q <= bits_d;
         cnt_q  <= cnt_d;
         word_q <= word_d;
         vld_q  <= vld_d;
         last_q <= last_d;
         wcnt_q <= wcnt_d;
         fc_q   <= fc_d;
      end
   end

   assign data_out_fifo_wr_data = word_q;
   assign data_out_valid        = vld_q;
   assign data_out_last         = last_q;
   assign frame_count           = fc_q;

endmodule

// File: doc/info_mapper_stream.md
Name: info_mapper_stream

Overview:
- Streaming, parametrised information-bit mapper with elastic buffering on both sides.
- Accepts IN_W-bit information words and a per-word P-bit mapping-indicator vector.
- Emits P-bit output words: information bits go in indicator-1 lanes, FROZEN_VAL goes in indicator-0 lanes.
- Adds valid/ready handshakes, decoupled input/output widths, frame framing with a last marker, optional per-frame residual flush, and a bypass mode. Sits between the info-bit FIFO and the encoder-input FIFO.

Parameters:
- P, 8: output lanes per word; also the mapping_indicators width. Must be at least 2.
- IN_W, 8: information bits per input word. Must be at least 1.
- FRAME_WORDS, 4: output words per frame. Must be at least 1.
- FROZEN_VAL, 0: bit value driven on indicator-0 lanes.
- FLUSH_AT_FRAME_END, 0: when 1, buffered bits left over after a frame's last word are discarded.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- data_in_fifo_rd_data  in  IN_W  information word; bit 0 is consumed first.
- data_in_valid  in  1  input word valid.
- data_in_ready  out  1  buffer can accept a full input word.
- mapping_indicators  in  P  lane mask for the next output word; 1 means information lane.
- mapping_valid  in  1  mask valid.
- mapping_ready  out  1  mask consumed this cycle.
- bypass  in  1  when 1, all P lanes are treated as information lanes (mask ignored); sampled with the mask.
- data_out_fifo_wr_data  out  P  mapped word.
- data_out_valid  out  1  output register holds a word.
- data_out_ready  in  1  downstream accepts.
- data_out_last  out  1  qualifies the final word of a frame.
- frame_count  out  16  completed frames, counted on acceptance of the last word; wraps at 2^16.

Behaviour:
- Localparams: BUF_BITS = P + IN_W; CW = clog2(BUF_BITS+1).
- State: bit buffer buf[BUF_BITS], count buf_cnt[CW], output register, word counter wcnt (0..FRAME_WORDS-1), frame_count.
- Reset values: buf_cnt=0, wcnt=0, frame_count=0, data_out_valid=0, data_out_last=0, data_out_fifo_wr_data=0. Reset mid-frame drops all buffered bits and any pending output word.
- data_in_ready = (buf_cnt <= BUF_BITS-IN_W), from registers only. The input fires on data_in_valid && data_in_ready.
- Effective mask: em = bypass ? all-ones : mapping_indicators. k = popcount(em), range 0..P.
- Load condition: load = mapping_valid && (!data_out_valid || data_out_ready) && (buf_cnt >= k). mapping_ready = load. The check uses registered buf_cnt; same-cycle input bits are never bypassed.
- On load:
  - Lane i gets buf[prefix(i)] if em[i]=1, else FROZEN_VAL; prefix(i) = number of ones in em[i-1:0].
  - The buffer shifts down by k.
  - data_out_valid is set to 1 next cycle.
  - data_out_last = (wcnt == FRAME_WORDS-1).
  - wcnt advances, wrapping to 0 after FRAME_WORDS-1.
- Simultaneous load and input fire: the new word is written at position buf_cnt-k; next buf_cnt = buf_cnt - k + IN_W.
- Input fire only: the word is written at position buf_cnt; buf_cnt += IN_W.
- A mask with k=0 loads with no buffer requirement and emits an all-FROZEN_VAL word.
- FLUSH_AT_FRAME_END=1, on loading a last word: remaining bits are discarded. A same-cycle input word is written at position 0 and buf_cnt = IN_W (or 0 if no input fire).
- Output handshake: the word is held stable while data_out_valid && !data_out_ready. Accepted when both are high. Without a new load in the same cycle, data_out_valid clears next cycle. A load in the accept cycle gives back-to-back words with no bubble.
- frame_count increments on acceptance of a word with data_out_last=1.
- Latency: an input accepted at edge n contributes to an output word loaded at edge n+1 at the earliest; data_out_valid is visible after that edge.
- Throughput: one word per cycle while the input supplies at least k bits per cycle on average.
- No deadlock: BUF_BITS >= IN_W+P-1 guarantees that either input fires or any k <= P load is possible.

Decomposition:
- Package info_mapper_pkg: clog2 helper; CW and prefix-width localparam functions; FROZEN_VAL default.
- Sub-module info_lane_mapper (combinational): inputs em, buffer window[P], FROZEN_VAL. Outputs the mapped word and k, built from a prefix-sum chain and a per-lane mux. Reused by future polar/systematic variants.

Test Plan:
- Reset, then P=8, IN_W=8, mask 8'b1111_0000, input 8'hA5, out_ready=1 -> word 8'h50 (buffer bits 1,0,1,0 in lanes 4..7). Then with mask 8'b0000_1111, no new input -> word 8'h0A. buf_cnt ends at 0.
- FRAME_WORDS=4, mask 8'hFF, input words 0x01..0x04 -> outputs 0x01..0x04; data_out_last only on 0x04; frame_count 0->1.
- Backpressure: hold data_out_ready=0 for 5 cycles with a word pending -> data stable, mapping_ready=0, input stalls once buf_cnt > 8; release -> no words lost or duplicated.
- k=0 mask 8'h00 with empty buffer -> immediate all-FROZEN_VAL word; FROZEN_VAL=1 gives 8'hFF. buf_cnt unchanged.
- FLUSH_AT_FRAME_END=1, FRAME_WORDS=1, mask 8'h0F, input 8'hFF -> output 8'h0F, leftover 4 bits dropped; next frame starts from the next input word's bit 0.
- Assert reset mid-frame with buf_cnt=12 and data_out_valid=1 -> next cycle all outputs are 0, data_in_ready=1, wcnt restarts at 0.
